// File: rtl/dmem_responder_if.sv
// ----------------------------------------------------------------------------
// dmem_if
// Data-memory port bundle between the core (master) and a memory responder
// (slave). It carries a valid/ready request channel and a valid/ready response
// channel.
//
// Request channel:
//   req_valid, req_ready, req_we, req_addr, req_wdata, req_size, req_unsigned
// Response channel:
//   rsp_valid, rsp_ready, rsp_rdata, rsp_err
// ----------------------------------------------------------------------------
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
// This is the responder end of the core's data-memory port. It is a
// multi-cycle data RAM that serves one load or store at a time with a fixed
// access latency. It supports byte, half and word sizing, and it sign- or
// zero-extends load data. Misaligned, out-of-range and illegal-size requests
// receive an error response.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    dmem_if.slave
//          request:  req_valid/req_ready, req_we, req_addr, req_wdata,
//                    req_size, req_unsigned
//          response: rsp_valid/rsp_ready, rsp_rdata, rsp_err
//
// Parameters:
//   DEPTH_WORDS  RAM depth in 32-bit words (power of two, >= 4)
//   LATENCY      cycles from accept to response (1..15)
// ----------------------------------------------------------------------------
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic clk,
    input  logic rst_n,
    dmem_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;

    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [1:0]  cap_size;
    logic        cap_uns;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          enter_resp;
    logic          do_write;
    logic          cur_we;
    logic [31:0]   cur_addr;
    logic [31:0]   cur_wdata;
    logic [1:0]    cur_size;
    logic          cur_uns;
    logic          cur_err;
    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word;
    logic [31:0]   rd_shift;
    logic [31:0]   load_val;
    logic [31:0]   resp_data;
    logic [3:0]    lane_en;
    logic [31:0]   lane_data;

    // For LATENCY == 1, the request is accepted and the RAM is accessed on the
    // same edge. The live bus values are therefore used while IDLE, and the
    // captured copies are used afterwards.
    always_comb begin
        accept     = (state == ST_IDLE) && bus.req_valid;
        enter_resp = (accept && (LATENCY == 1)) || ((state == ST_WAIT) && (cnt == 4'd1));

        if (state == ST_IDLE) begin
            cur_we    = bus.req_we;
            cur_addr  = bus.req_addr;
            cur_wdata = bus.req_wdata;
            cur_size  = bus.req_size;
            cur_uns   = bus.req_unsigned;
        end else begin
            cur_we    = cap_we;
            cur_addr  = cap_addr;
            cur_wdata = cap_wdata;
            cur_size  = cap_size;
            cur_uns   = cap_uns;
        end

        cur_err = (cur_size == 2'b11) ||
                  ((cur_size == 2'b01) && cur_addr[0]) ||
                  ((cur_size == 2'b10) && (cur_addr[1:0] != 2'b00)) ||
                  ({2'b00, cur_addr[31:2]} >= DEPTH_WORDS);

        word_idx = cur_addr[AW+1:2];
        rd_word  = mem[word_idx];
        rd_shift = rd_word >> {cur_addr[1:0], 3'b000};

        case (cur_size)
            2'b00:   load_val = cur_uns ? {24'h0, rd_shift[7:0]}
                                        : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   load_val = cur_uns ? {16'h0, rd_shift[15:0]}
                                        : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: load_val = rd_word;
        endcase

        resp_data = (cur_err || cur_we) ? '0 : load_val;

        case (cur_size)
            2'b00: begin
                lane_en   = 4'b0001 << cur_addr[1:0];
                lane_data = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                lane_en   = cur_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{cur_wdata[15:0]}};
            end
            default: begin
                lane_en   = 4'b1111;
                lane_data = cur_wdata;
            end
        endcase

        // Gating with rst_n blocks a commit on an edge while reset is held.
        do_write = rst_n && enter_resp && cur_we && !cur_err;
    end

    // The RAM array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[word_idx][i*8 +: 8] <= lane_data[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            cap_we        <= 1'b0;
            cap_addr      <= '0;
            cap_wdata     <= '0;
            cap_size      <= '0;
            cap_uns       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cap_we        <= bus.req_we;
                        cap_addr      <= bus.req_addr;
                        cap_wdata     <= bus.req_wdata;
                        cap_size      <= bus.req_size;
                        cap_uns       <= bus.req_unsigned;
                        bus.req_ready <= 1'b0;
                        if (enter_resp) begin
                            state         <= ST_RESP;
                            cnt           <= '0;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_rdata <= resp_data;
                            bus.rsp_err   <= cur_err;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= 4'(LATENCY - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd1) begin
                        state         <= ST_RESP;
                        cnt           <= '0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= resp_data;
                        bus.rsp_err   <= cur_err;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= ST_IDLE;
                        bus.req_ready <= 1'b1;
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_rdata <= '0;
                        bus.rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    bus.req_ready <= 1'b1;
                    bus.rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
